jp_poller: RTL and testbench

- Autonomous controller front end. It polls both physical NES pads over their latch/clock/data pins and holds a debounced 8-bit button image per port.
- Toward rp2a03 it emulates a 4021 shift register. It accepts rp2a03's latch/clock strobes and returns the serial stream with pad pin polarity.
- It sits between the board jp_* pins and rp2a03's jp_data inputs, and replaces the inline jp sync/disable logic in the top level.

---
 rtl/jp_pkg.sv | 28 ++
 rtl/jp_shadow4021.sv | 33 +++
 rtl/jp_poller.sv | 183 ++++++++++++++++++
 tb/tb_jp_poller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jp_pkg.sv
// Shared definitions for the joypad poller: FSM encoding, button bit positions, timing defaults.
package jp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_GAP,
        ST_CLK_HI,
        ST_CLK_LO,
        ST_COMMIT
    } poll_state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam int NUM_PORTS = 2;

    // 25 MHz clock: 150 cycles = 6 us pad half-bit, 416667 cycles = 60 Hz poll rate
    localparam int CLK_DIV_DEFAULT     = 150;
    localparam int POLL_PERIOD_DEFAULT = 416667;

endpackage

// File: rtl/jp_shadow4021.sv
// Emulated 4021 parallel-in/serial-out register presented to rp2a03 for one port.
module jp_shadow4021
    import jp_pkg::*;
(
    input  logic       clk_25,
    input  logic       rst,
    input  logic       latch,
    input  logic       shift_clk,
    input  logic [7:0] btn,
    output logic       data
);

    logic [7:0] shadow;
    logic       shift_clk_prev;

    // Latch has priority over a coincident clock edge; shifting back-fills with 1 (released).
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            shadow         <= 8'hFF;
            shift_clk_prev <= 1'b1;
        end else begin
            shift_clk_prev <= shift_clk;
            if (latch) begin
                shadow <= ~btn;
            end else if (shift_clk && !shift_clk_prev) begin
                shadow <= {1'b1, shadow[7:1]};
            end
        end
    end

    assign data = shadow[0];

endmodule

// File: rtl/jp_poller.sv
// Autonomous NES pad poller with debounced button images and emulated 4021 outputs to rp2a03.
// Optional: define JP_DISCONNECT_DETECT_EN to track pad presence and mask absent ports.
module jp_poller
    import jp_pkg::*;
#(
    parameter int CLK_DIV     = CLK_DIV_DEFAULT,
    parameter int POLL_PERIOD = POLL_PERIOD_DEFAULT
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic       poll_req,
    input  logic [1:0] pad_data_in,
    output logic       pad_latch_out,
    output logic       pad_clk_out,
    input  logic       emu_latch_in,
    input  logic [1:0] emu_clk_in,
    output logic [1:0] emu_data_out,
    output logic [7:0] btn1_out,
    output logic [7:0] btn2_out,
    output logic [1:0] connected_out,
    output logic       busy_out
);

    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TIMER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;

    logic [1:0]         pad_sync1;
    logic [1:0]         pad_sync;
    logic [TIMER_W-1:0] timer_q;
    logic               tick;
    logic               start;
    poll_state_t        state;
    logic [DIV_W-1:0]   div_q;
    logic               div_end;
    logic               latch_half;
    logic [2:0]         bit_idx;
    logic [1:0][7:0]    temp_q;
    logic [1:0]         shadow_data;

    // Two-flop synchroniser; resets low so presence detection only trusts real pin activity.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            pad_sync1 <= 2'b00;
            pad_sync  <= 2'b00;
        end else begin
            pad_sync1 <= pad_data_in;
            pad_sync  <= pad_sync1;
        end
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (tick) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + TIMER_W'(1);
        end
    end

    assign tick    = (timer_q == TIMER_W'(POLL_PERIOD - 1));
    assign start   = tick | poll_req;
    assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

`ifdef JP_DISCONNECT_DETECT_EN
    logic [1:0] connected_q;

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            connected_q <= 2'b00;
        end else begin
            connected_q <= connected_q | pad_sync;
        end
    end

    assign connected_out = connected_q;
`else
    assign connected_out = 2'b11;
`endif

    // Poll sequencer; LATCH spans two divider periods, tracked by latch_half.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            div_q         <= '0;
            latch_half    <= 1'b0;
            bit_idx       <= 3'd0;
            temp_q        <= '0;
            pad_latch_out <= 1'b0;
            pad_clk_out   <= 1'b1;
            busy_out      <= 1'b0;
            btn1_out      <= 8'h00;
            btn2_out      <= 8'h00;
        end else begin
            if (state == ST_IDLE || state == ST_COMMIT || div_end) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state         <= ST_LATCH;
                        busy_out      <= 1'b1;
                        pad_latch_out <= 1'b1;
                        latch_half    <= 1'b0;
                    end
                end
                ST_LATCH: begin
                    if (div_end) begin
                        latch_half <= ~latch_half;
                        if (latch_half) begin
                            state         <= ST_GAP;
                            pad_latch_out <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (div_end) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            temp_q[p][0] <= ~pad_sync[p];
                        end
                        bit_idx     <= 3'd1;
                        state       <= ST_CLK_HI;
                        pad_clk_out <= 1'b0;
                    end
                end
                ST_CLK_HI: begin
                    if (div_end) begin
                        state       <= ST_CLK_LO;
                        pad_clk_out <= 1'b1;
                    end
                end
                ST_CLK_LO: begin
                    if (div_end) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            temp_q[p][bit_idx] <= ~pad_sync[p];
                        end
                        if (bit_idx == 3'd7) begin
                            state <= ST_COMMIT;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            state       <= ST_CLK_HI;
                            pad_clk_out <= 1'b0;
                        end
                    end
                end
                ST_COMMIT: begin
                    btn1_out <= temp_q[0] & {8{connected_out[0]}};
                    btn2_out <= temp_q[1] & {8{connected_out[1]}};
                    busy_out <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    jp_shadow4021 u_shadow1 (
        .clk_25    (clk_25),
        .rst       (rst),
        .latch     (emu_latch_in),
        .shift_clk (emu_clk_in[0]),
        .btn       (btn1_out),
        .data      (shadow_data[0])
    );

    jp_shadow4021 u_shadow2 (
        .clk_25    (clk_25),
        .rst       (rst),
        .latch     (emu_latch_in),
        .shift_clk (emu_clk_in[1]),
        .btn       (btn2_out),
        .data      (shadow_data[1])
    );

    // An absent port always reads as released toward the CPU.
    assign emu_data_out = shadow_data | ~connected_out;

endmodule

// File: tb/tb_jp_poller.sv
// Directed bench for jp_poller with a pad 4021 model and scoreboard queues.
module tb_jp_poller;

    localparam int D           = 4;
    localparam int P           = 1000;
    // 2D latch + D gap + 7 clock periods of 2D + one commit cycle
    localparam int POLL_CYCLES = 2*D + D + 7*2*D + 1;

`ifdef JP_DISCONNECT_DETECT_EN
    localparam logic [7:0] EXP_BTN2 = 8'h00;
    localparam logic [1:0] EXP_CONN = 2'b01;
    localparam logic [1:0] RST_CONN = 2'b00;
`else
    localparam logic [7:0] EXP_BTN2 = 8'hFF;
    localparam logic [1:0] EXP_CONN = 2'b11;
    localparam logic [1:0] RST_CONN = 2'b11;
`endif

    logic       clk_25 = 1'b0;
    logic       rst = 1'b1;
    logic       poll_req = 1'b0;
    logic [1:0] pad_data_in;
    logic       pad_latch_out;
    logic       pad_clk_out;
    logic       emu_latch_in = 1'b0;
    logic [1:0] emu_clk_in = 2'b11;
    logic [1:0] emu_data_out;
    logic [7:0] btn1_out;
    logic [7:0] btn2_out;
    logic [1:0] connected_out;
    logic       busy_out;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rst_cyc = 0;

    logic [15:0] poll_q[$];
    logic [1:0]  emu_q[$];

    logic [7:0] pad1_btns = 8'h00;
    logic [7:0] pad1_sr = 8'hFF;

    jp_poller #(.CLK_DIV(D), .POLL_PERIOD(P)) dut (
        .clk_25        (clk_25),
        .rst           (rst),
        .poll_req      (poll_req),
        .pad_data_in   (pad_data_in),
        .pad_latch_out (pad_latch_out),
        .pad_clk_out   (pad_clk_out),
        .emu_latch_in  (emu_latch_in),
        .emu_clk_in    (emu_clk_in),
        .emu_data_out  (emu_data_out),
        .btn1_out      (btn1_out),
        .btn2_out      (btn2_out),
        .connected_out (connected_out),
        .busy_out      (busy_out)
    );

    always #20 clk_25 = ~clk_25;

    // Port 1 pad: real 4021 behaviour; port 2 pin is held low (absent or all pressed).
    always @(posedge pad_latch_out or posedge pad_clk_out) begin
        if (pad_latch_out) pad1_sr <= ~pad1_btns;
        else               pad1_sr <= {1'b1, pad1_sr[7:1]};
    end

    assign pad_data_in = {1'b0, pad1_sr[0]};

    task automatic step();
        @(posedge clk_25);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] btns, input logic use_req);
        pad1_btns = btns;
        poll_q.push_back({EXP_BTN2, btns});
        if (use_req) begin
            poll_req = 1'b1;
            step();
            poll_req = 1'b0;
        end
    endtask

    task automatic checkPoll(input string tag);
        logic [15:0] exp;
        exp = poll_q.pop_front();
        checkOutput(tag, {btn2_out, btn1_out}, exp);
    endtask

    task automatic waitCommit(input string tag);
        int n = 0;
        while (busy_out !== 1'b0 && n < 4*POLL_CYCLES) begin
            step();
            n++;
        end
        checkOutput({tag, " idle"}, busy_out, 0);
        checkPoll(tag);
    endtask

    task automatic emuSample(input string tag);
        logic [1:0] exp;
        exp = emu_q.pop_front();
        checkOutput(tag, emu_data_out, exp);
    endtask

    initial begin
        int busy_cycles, latch_cycles, clk_low, pulses, w, min_w, max_w, commits;
        logic prev_clk, prev_busy;
        logic [7:0] m1, m2;

        // Reset state
        step();
        checkOutput("reset outputs", {pad_latch_out, pad_clk_out, emu_data_out, busy_out},
                    {1'b0, 1'b1, 2'b11, 1'b0});
        checkOutput("reset btn", {btn2_out, btn1_out}, 16'h0000);
        checkOutput("reset connected", connected_out, RST_CONN);
        step();
        rst = 1'b0;
        rst_cyc = cyc;
        repeat (4) step();

        // Poll with A+Start pressed, watching the pad waveform each cycle
        applyStimulus(8'h09, 1'b1);
        busy_cycles = 0; latch_cycles = 0; clk_low = 0; pulses = 0;
        w = 0; min_w = 1000; max_w = 0; prev_clk = 1'b1;
        while (busy_out && busy_cycles < 4*POLL_CYCLES) begin
            busy_cycles++;
            if (pad_latch_out) latch_cycles++;
            if (!pad_clk_out) begin
                clk_low++;
                w++;
                if (prev_clk) pulses++;
            end else if (!prev_clk) begin
                if (w < min_w) min_w = w;
                if (w > max_w) max_w = w;
                w = 0;
            end
            prev_clk = pad_clk_out;
            step();
        end
        checkOutput("busy length", busy_cycles, POLL_CYCLES);
        checkOutput("latch width", latch_cycles, 2*D);
        checkOutput("clk pulses", pulses, 7);
        checkOutput("clk low total", clk_low, 7*D);
        checkOutput("clk pulse min", min_w, D);
        checkOutput("clk pulse max", max_w, D);
        checkOutput("pins idle", {pad_latch_out, pad_clk_out}, 2'b01);
        checkPoll("poll 09");
        checkOutput("connected", connected_out, EXP_CONN);

        // rp2a03 read of the shadow registers
        m1 = ~8'h09;
        m2 = ~EXP_BTN2;
        emu_latch_in = 1'b1;
        step(); step();
        emu_latch_in = 1'b0;
        step();
        emu_q.push_back({m2[0], m1[0]});
        emuSample("emu bit0");
        for (int i = 1; i <= 10; i++) begin
            emu_clk_in = 2'b00;
            step();
            emu_clk_in = 2'b11;
            m1 = {1'b1, m1[7:1]};
            m2 = {1'b1, m2[7:1]};
            emu_q.push_back({m2[0], m1[0]});
            step();
            emuSample($sformatf("emu edge %0d", i));
        end
        // Latch and edge in the same cycle: latch must win
        emu_clk_in = 2'b00;
        step();
        emu_latch_in = 1'b1;
        emu_clk_in = 2'b11;
        step();
        emu_latch_in = 1'b0;
        m1 = ~8'h09;
        m2 = ~EXP_BTN2;
        emu_q.push_back({m2[0], m1[0]});
        step();
        emuSample("emu latch wins");

        // Second request during busy is dropped
        applyStimulus(8'hA5, 1'b1);
        repeat (10) step();
        checkOutput("busy mid poll", busy_out, 1);
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        commits = 0;
        prev_busy = busy_out;
        for (int i = 0; i < 3*POLL_CYCLES; i++) begin
            step();
            if (prev_busy && !busy_out) commits++;
            prev_busy = busy_out;
        end
        checkOutput("single commit", commits, 1);
        checkPoll("poll A5");

        // Reset during CLK_LO of bit 4
        applyStimulus(8'h3C, 1'b1);
        repeat (10*D + 2) step();
        checkOutput("mid bit4", {busy_out, pad_clk_out, pad_latch_out}, 3'b110);
        rst = 1'b1;
        #1;
        checkOutput("rst pins", {busy_out, pad_clk_out, pad_latch_out}, 3'b010);
        checkOutput("rst btn", {btn2_out, btn1_out}, 16'h0000);
        void'(poll_q.pop_back());
        step(); step();
        rst = 1'b0;
        rst_cyc = cyc;
        applyStimulus(8'h3C, 1'b1);
        waitCommit("poll after rst");

        // Period tick coinciding with poll_req starts one poll only
        applyStimulus(8'h5A, 1'b0);
        while (cyc - rst_cyc < P - 1) step();
        poll_req = 1'b1;
        step();
        poll_req = 1'b0;
        checkOutput("tick+req start", busy_out, 1);
        commits = 0;
        prev_busy = busy_out;
        for (int i = 0; i < 3*POLL_CYCLES; i++) begin
            step();
            if (prev_busy && !busy_out) commits++;
            prev_busy = busy_out;
        end
        checkOutput("tick+req commits", commits, 1);
        checkPoll("poll 5A");

        // Period timer alone
        applyStimulus(8'h81, 1'b0);
        while (cyc - rst_cyc < 2*P - 1) step();
        checkOutput("idle before tick", busy_out, 0);
        step();
        checkOutput("tick start", busy_out, 1);
        waitCommit("poll 81");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
